frame_buf_writer: RTL

//  Write side of the LED-matrix frame buffer. Accepts a valid/ready RGB332 pixel stream and writes
//  it row-major into the frame-buffer RAM. The scan driver reads that RAM with read_addr/pixel_data.

---
 rtl/frame_buf_writer_pkg.sv | 19 +
 rtl/frame_buf_writer_if.sv | 13 +
 rtl/frame_buf_writer_pixel_addr_gen.sv | 45 ++++
 rtl/frame_buf_writer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/frame_buf_writer_pkg.sv
// Shared LED-matrix constants and types for the frame-buffer write path.
package led_pkg;

    localparam int MATRIX_SIZE = 8;
    localparam int COLOR_DEPTH = 8;
    localparam int ADDR_WIDTH  = 6;
    localparam int COORD_WIDTH = ADDR_WIDTH / 2;

    typedef logic [COLOR_DEPTH-1:0] pixel_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [COORD_WIDTH-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_SWAP
    } fbw_state_t;

endpackage

// File: rtl/frame_buf_writer_if.sv
// Valid/ready RGB332 pixel stream between the pixel source (master) and the writer (slave).
interface frame_buf_writer_if;
    import led_pkg::*;

    logic   s_valid;
    logic   s_ready;
    logic   s_sof;
    pixel_t s_data;

    modport master (output s_valid, output s_sof, output s_data, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_data, output s_ready);

endinterface

// File: rtl/frame_buf_writer_pixel_addr_gen.sv
// Row/column pixel counter for the frame-buffer writer; both counters wrap at MATRIX_SIZE-1.
module pixel_addr_gen
    import led_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  inc_i,
    output addr_t addr_o,
    output logic  last_o
);

    localparam coord_t LAST_COORD = coord_t'(MATRIX_SIZE - 1);

    coord_t row_q, row_d;
    coord_t col_q, col_d;

    // Clear and increment together yield position 1: the sof pixel itself goes to address 0.
    always_comb begin
        row_d = clr_i ? '0 : row_q;
        col_d = clr_i ? '0 : col_q;
        if (inc_i) begin
            if (col_d == LAST_COORD) begin
                col_d = '0;
                row_d = (row_d == LAST_COORD) ? '0 : row_d + coord_t'(1);
            end else begin
                col_d = col_d + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign addr_o = {row_q, col_q};
    assign last_o = (row_q == LAST_COORD) && (col_q == LAST_COORD);

endmodule

// File: rtl/frame_buf_writer.sv
// Writes an RGB332 pixel stream row-major into the frame-buffer RAM.
// Define DOUBLE_BUF_EN for two banks swapped only at a scan frame boundary.
module frame_buf_writer
    import led_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    frame_buf_writer_if.slave        pix,
    input  logic                     scan_frame_end,
    output logic                     wr_en,
    output addr_t                    wr_addr,
    output pixel_t                   wr_data,
    output logic                     wr_bank,
    output logic                     rd_bank,
    output logic                     frame_done,
    output logic                     frame_err
);

    fbw_state_t state_q, state_d;
    logic       wr_en_q, wr_en_d;
    addr_t      wr_addr_q, wr_addr_d;
    pixel_t     wr_data_q, wr_data_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       cnt_clr, cnt_inc;
    addr_t      cnt_addr;
    logic       cnt_last;
    logic       accept;

`ifdef DOUBLE_BUF_EN
    logic rd_bank_q, rd_bank_d;
    logic wr_bank_q, wr_bank_d;
    assign pix.s_ready = (state_q != WAIT_SWAP);
`else
    logic unused_scan_frame_end;
    assign pix.s_ready           = 1'b1;
    assign unused_scan_frame_end = scan_frame_end;
`endif

    assign accept = pix.s_valid && pix.s_ready;

    pixel_addr_gen u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`ifdef DOUBLE_BUF_EN
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (pix.s_sof) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = pix.s_data;
                        cnt_clr   = 1'b1;
                        cnt_inc   = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = pix.s_data;
                    cnt_inc   = 1'b1;
                    if (pix.s_sof) begin
                        // A stray sof restarts the frame rather than being dropped.
                        err_d     = 1'b1;
                        wr_addr_d = '0;
                        cnt_clr   = 1'b1;
                    end else begin
                        wr_addr_d = cnt_addr;
                        if (cnt_last) begin
                            done_d = 1'b1;
`ifdef DOUBLE_BUF_EN
                            state_d = WAIT_SWAP;
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
            end
`ifdef DOUBLE_BUF_EN
            WAIT_SWAP: begin
                if (scan_frame_end) begin
                    rd_bank_d = ~rd_bank_q;
                    wr_bank_d = rd_bank_q;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b1;
        end else begin
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    assign rd_bank = rd_bank_q;
    assign wr_bank = wr_bank_q;
`else
    assign rd_bank = 1'b0;
    assign wr_bank = 1'b0;
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
